// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared state/error encodings and default frame constants for uart_cmd_parser
package uart_cmd_pkg;
    typedef enum logic [2:0] {S_SYNC, S_OP, S_ADDR, S_DATA, S_CHK, S_ISSUE} state_t;
    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BAD_OP  = 2'd1,
        ERR_BAD_CHK = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [7:0] OP_WRITE_DEF  = 8'h01;
    localparam logic [7:0] OP_READ_DEF   = 8'h02;
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles SYNC/OP/ADDR/DATA/CHK frames from a byte stream into register commands
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter logic [7:0] OP_WRITE       = OP_WRITE_DEF,
    parameter logic [7:0] OP_READ        = OP_READ_DEF,
    parameter int         TIMEOUT_CYCLES = 50_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       cmd_write,
    output logic [7:0] cmd_addr,
    output logic [7:0] cmd_data,
    output logic       err_valid,
    output logic [1:0] err_code,
    output logic [7:0] err_count
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state, state_nxt;
    err_code_t     code;
    logic [7:0]    chk, addr_q, data_q;
    logic          wr_q, accept, active, expire, op_ok, hs, err;
    logic [CW-1:0] cnt;

    assign in_ready = ena && (state != S_ISSUE);
    assign accept   = ena && in_valid && in_ready;
    assign active   = (state == S_OP) || (state == S_ADDR) || (state == S_DATA) || (state == S_CHK);
    // an accept in the expiry cycle wins over the timeout
    assign expire   = ena && active && !accept && (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign op_ok    = (in_data == OP_WRITE) || (in_data == OP_READ);
    assign hs       = ena && cmd_valid && cmd_ready;

    always_comb begin
        state_nxt = state;
        err       = 1'b0;
        code      = ERR_NONE;
        case (state)
            S_SYNC:  if (accept && in_data == SYNC_BYTE) state_nxt = S_OP;
            S_OP:    if (accept) begin
                state_nxt = op_ok ? S_ADDR : S_SYNC;
                err       = !op_ok;
                code      = ERR_BAD_OP;
            end
            S_ADDR:  if (accept) state_nxt = S_DATA;
            S_DATA:  if (accept) state_nxt = S_CHK;
            S_CHK:   if (accept) begin
                state_nxt = (in_data == chk) ? S_ISSUE : S_SYNC;
                err       = (in_data != chk);
                code      = ERR_BAD_CHK;
            end
            S_ISSUE: if (hs) state_nxt = S_SYNC;
            default: state_nxt = S_SYNC;
        endcase
        if (expire) begin
            state_nxt = S_SYNC;
            err       = 1'b1;
            code      = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_SYNC;
            cnt   <= '0;
        end else if (ena) begin
            state <= state_nxt;
            cnt   <= (accept || state_nxt == S_SYNC || state_nxt == S_ISSUE) ? '0 : cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk       <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            cmd_valid <= 1'b0;
            cmd_write <= 1'b0;
            cmd_addr  <= '0;
            cmd_data  <= '0;
            err_valid <= 1'b0;
            err_code  <= '0;
            err_count <= '0;
        end else if (ena) begin
            if (accept) begin
                if (state == S_SYNC) chk <= '0;
                if (state == S_OP || state == S_ADDR || state == S_DATA) chk <= chk ^ in_data;
                if (state == S_OP) wr_q <= (in_data == OP_WRITE);
                if (state == S_ADDR) addr_q <= in_data;
                if (state == S_DATA) data_q <= in_data;
            end
            if (state == S_CHK && state_nxt == S_ISSUE) begin
                cmd_write <= wr_q;
                cmd_addr  <= addr_q;
                cmd_data  <= data_q;
            end
            cmd_valid <= (state_nxt == S_ISSUE);
            err_valid <= err;
            if (err) begin
                err_code  <= code;
                err_count <= sat_inc(err_count);
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: randomized byte streams checked by a frame-level model through a scoreboard
module tb_uart_cmd_parser;
    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       reset, ena, in_valid, in_ready, cmd_valid, cmd_ready, cmd_write, err_valid;
    logic [7:0] in_data, cmd_addr, cmd_data, err_count;
    logic [1:0] err_code;

    uart_cmd_parser #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .ena(ena),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .err_valid(err_valid), .err_code(err_code), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic w; logic [7:0] a; logic [7:0] d; int t; } cmd_t;
    typedef struct { logic [1:0] c; logic [7:0] n; int t; } err_t;
    cmd_t cq[$];
    err_t eq[$];

    int tests = 0, fails = 0;
    int rdy_p = 100, en_p = 100;

    // reference model: position within the frame plus the bytes seen so far
    int         pos = 0, idle = 0;
    logic [7:0] fr[5];
    logic [7:0] m_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic m_err(input logic [1:0] c);
        err_t e;
        if (m_cnt != 8'hFF) m_cnt++;
        e.c = c; e.n = m_cnt; e.t = cyc;
        eq.push_back(e);
        pos = 0;
    endtask

    task automatic m_byte(input logic [7:0] b);
        cmd_t c;
        idle = 0;
        fr[pos] = b;
        if (pos == 0) pos = (b == 8'hA5) ? 1 : 0;
        else if (pos == 1) begin
            if (b == 8'h01 || b == 8'h02) pos = 2;
            else m_err(2'd1);
        end else if (pos < 4) pos++;
        else if (b == (fr[1] ^ fr[2] ^ fr[3])) begin
            c.w = (fr[1] == 8'h01); c.a = fr[2]; c.d = fr[3]; c.t = cyc;
            cq.push_back(c);
            pos = 0;
        end else m_err(2'd2);
    endtask

    task automatic tick(input logic v, input logic [7:0] d, input logic e, output logic acc);
        in_valid  = v;
        in_data   = d;
        ena       = e;
        cmd_ready = ($urandom_range(99) < rdy_p);
        #1;
        acc = v && e && in_ready;
        if (!e) check("in_ready_ena_low", in_ready, 0);
        @(posedge clk);
        #1;
        if (acc) m_byte(d);
        else if (e && pos > 0) begin
            idle++;
            if (idle == TMO) m_err(2'd3);
        end
    endtask

    task automatic idle_n(input int n);
        logic acc;
        for (int i = 0; i < n; i++) tick(1'b0, 8'($urandom), $urandom_range(99) < en_p, acc);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        logic acc;
        int   n;
        idle_n(gap);
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 2000) begin
            tick(1'b1, b, $urandom_range(99) < en_p, acc);
            n++;
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL accept_bound: byte %0h not accepted within 2000 cycles", b);
        end
    endtask

    task automatic send_n(input logic [39:0] f, input int nb, input int gmax);
        for (int i = 0; i < nb; i++) begin
            send(f[39-8*i -: 8], ($urandom_range(19) == 0) ? $urandom_range(100, 130) : $urandom_range(gmax));
        end
    endtask

    task automatic send5(input logic [39:0] f);
        for (int i = 0; i < 5; i++) send(f[39-8*i -: 8], 0);
    endtask

    // monitor: pops expectations whenever the DUT presents a command or an error
    initial begin
        cmd_t cur;
        err_t e;
        logic last_en, last_hs, holding;
        last_en = 0; last_hs = 0; holding = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                last_en = 0; last_hs = 0; holding = 0;
            end else begin
                if (last_hs) check("cmd_valid_drop", cmd_valid, 0);
                if (cmd_valid && !holding) begin
                    if (cq.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_cmd: got w=%0b a=%0h d=%0h expected none", cmd_write, cmd_addr, cmd_data);
                    end else begin
                        cur = cq.pop_front();
                        check("cmd_cycle", cyc, cur.t);
                        check("cmd_write", cmd_write, cur.w);
                        check("cmd_addr", cmd_addr, cur.a);
                        check("cmd_data", cmd_data, cur.d);
                    end
                    holding = 1;
                end else if (cmd_valid) begin
                    check("cmd_stable", {cmd_write, cmd_addr, cmd_data}, {cur.w, cur.a, cur.d});
                end
                if (cmd_valid) check("in_ready_issue", in_ready, 0);
                if (!cmd_valid) holding = 0;
                if (err_valid && last_en) begin
                    if (eq.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_err: got code=%0d count=%0d expected none", err_code, err_count);
                    end else begin
                        e = eq.pop_front();
                        check("err_cycle", cyc, e.t);
                        check("err_code", err_code, e.c);
                        check("err_count", err_count, e.n);
                    end
                end
                last_hs = cmd_valid && cmd_ready && ena;
                last_en = ena;
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_cmd_valid"}, cmd_valid, 0);
        check({tag, "_cmd_fields"}, {cmd_write, cmd_addr, cmd_data}, 0);
        check({tag, "_err_valid"}, err_valid, 0);
        check({tag, "_err_code"}, err_code, 0);
        check({tag, "_err_count"}, err_count, 0);
    endtask

    initial begin
        logic       acc;
        logic [7:0] op, a, d, ck;
        int         kind;
        reset = 1; ena = 0; in_valid = 0; in_data = 0; cmd_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        check("reset_in_ready", in_ready, 0);
        reset = 0;
        ena = 1;
        #1;
        check("in_ready_idle", in_ready, 1);

        send5(40'hA5_01_10_3C_2D);
        idle_n(4);
        rdy_p = 0;
        send5(40'hA5_02_7F_00_7D);
        idle_n(20);
        check("read_held", cmd_valid, 1);
        check("read_in_ready", in_ready, 0);
        rdy_p = 100;
        idle_n(3);
        check("read_released", cmd_valid, 0);

        send(8'h00, 0); send(8'hFF, 0); send(8'h5A, 0);
        idle_n(2);
        check("garbage_no_err", err_count, 0);
        send5(40'hA5_01_10_3C_2D);
        idle_n(4);

        send(8'hA5, 0); send(8'h03, 0);
        idle_n(2);
        check("bad_op_count", err_count, 1);
        send5(40'hA5_01_10_3C_2C);
        idle_n(3);
        check("bad_chk_count", err_count, 2);
        check("bad_chk_no_cmd", cmd_valid, 0);

        send(8'hA5, 0); send(8'h01, 0);
        idle_n(105);
        check("timeout_code", err_code, 3);
        send5(40'hA5_02_33_44_75);
        idle_n(4);

        send(8'hA5, 0); send(8'h01, 0); send(8'h10, 0);
        reset = 1;
        #1;
        check_zero("midreset");
        pos = 0; idle = 0; m_cnt = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 0;
        idle_n(3);
        check("midreset_no_err", err_count, 0);
        send5(40'hA5_01_20_55_74);
        idle_n(4);

        send(8'hA5, 0); send(8'h01, 0);
        for (int i = 0; i < 5; i++) tick(1'b1, 8'h10, 1'b0, acc);
        send(8'h10, 0); send(8'h3C, 0); send(8'h2D, 0);
        idle_n(4);

        en_p = 90;
        for (int n = 0; n < 300; n++) begin
            rdy_p = $urandom_range(20, 100);
            kind  = $urandom_range(9);
            op = $urandom_range(1) ? 8'h01 : 8'h02;
            a  = 8'($urandom);
            d  = 8'($urandom);
            if (kind == 6) op = 8'($urandom);
            ck = op ^ a ^ d;
            if (kind == 7) ck = ck ^ 8'($urandom_range(1, 255));
            if (kind == 8) begin
                for (int i = 0; i < $urandom_range(1, 3); i++) begin
                    op = 8'($urandom);
                    send((op == 8'hA5) ? 8'h00 : op, $urandom_range(2));
                end
            end else begin
                send_n({8'hA5, op, a, d, ck}, (kind == 9) ? $urandom_range(1, 4) : 5, 2);
            end
        end
        rdy_p = 100;
        en_p  = 100;
        idle_n(20);
        check("cmd_queue_drained", cq.size(), 0);
        check("err_queue_drained", eq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART receiver: consumes its byte stream via valid/ready and assembles fixed 5-byte command frames.
- Frame format: SYNC, OPCODE, ADDR, DATA, CHK, where CHK = OPCODE ^ ADDR ^ DATA.
- Validated frames are issued as single register read/write requests on a valid/ready command port.
- Malformed, corrupt or stalled frames are dropped and reported on an error pulse.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- OP_WRITE, 8'h01, opcode for a write request.
- OP_READ, 8'h02, opcode for a read request.
- TIMEOUT_CYCLES, 50_000, maximum enabled cycles allowed between accepted bytes inside a frame. Must be ≥ 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- ena  input  1  global enable. When low, all state is frozen.
- in_data  input  8  received byte (from the receiver's rx_data).
- in_valid  input  1  byte available (from rx_valid).
- in_ready  output  1  byte accepted (to rx_ready).
- cmd_valid  output  1  command pending.
- cmd_ready  input  1  consumer accepts the command.
- cmd_write  output  1  1 = write, 0 = read.
- cmd_addr  output  8  register address.
- cmd_data  output  8  write data. Don't-care for reads, but still driven with the received byte.
- err_valid  output  1  one-cycle error pulse.
- err_code  output  2  code of the last error: 01 BAD_OP, 10 BAD_CHK, 11 TIMEOUT.
- err_count  output  8  saturating error counter.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: state S_SYNC; cmd_valid 0, cmd_write 0, cmd_addr 0, cmd_data 0; err_valid 0, err_code 0, err_count 0; checksum accumulator 0; timeout counter 0.
- A reset asserted mid-frame or mid-issue abandons everything immediately and produces no error.
- Byte acceptance ("accept"): ena && in_valid && in_ready.
- in_ready: combinational, ena && (state != S_ISSUE). Backpressure is applied only while a command is pending.
- State S_SYNC:
  - Accepted byte == SYNC_BYTE: go to S_OP and clear the checksum accumulator.
  - Any other byte: discard silently (no error) and stay in S_SYNC.
- State S_OP:
  - Accepted byte == OP_WRITE or OP_READ: latch the write flag, XOR the byte into the checksum, go to S_ADDR.
  - Any other value, including SYNC_BYTE: raise BAD_OP and return to S_SYNC.
- State S_ADDR: on accept, latch the address, XOR it into the checksum, go to S_DATA.
- State S_DATA: on accept, latch the data, XOR it into the checksum, go to S_CHK. The DATA byte is present for reads as well.
- State S_CHK:
  - Accepted byte == checksum accumulator: load cmd_write/addr/data, set cmd_valid on the next edge, go to S_ISSUE.
  - Mismatch: raise BAD_CHK and return to S_SYNC.
- Latency: cmd_valid rises the cycle after the CHK byte is accepted.
- State S_ISSUE:
  - cmd_valid is held high and cmd_* are stable until cmd_valid && cmd_ready && ena.
  - On that handshake, cmd_valid clears on the next edge and the state goes to S_SYNC.
  - A new SYNC byte can be accepted in the cycle after the handshake.
- Timeout:
  - Active only in S_OP through S_CHK.
  - The counter clears on every accept and increments on each ena cycle without an accept.
  - When it reaches TIMEOUT_CYCLES-1 with no accept that cycle: raise TIMEOUT and return to S_SYNC.
  - The counter is held at 0 in S_SYNC and S_ISSUE.
  - Width is $clog2(TIMEOUT_CYCLES+1).
- Error raise:
  - err_valid is high for exactly one cycle on the edge after the error condition.
  - err_code updates in the same cycle and holds until the next error.
  - err_count increments and saturates at 255.
- Simultaneous events: an accept in the same cycle the counter would expire takes priority. The byte is processed and no timeout is raised.
- ena low: no state, counter, or output register changes; in_ready is 0. Pending cmd_valid stays high, but a handshake is not taken.
- Illegal state encoding: return to S_SYNC with no error.

Decomposition:
- Package uart_cmd_pkg:
  - state enum (S_SYNC, S_OP, S_ADDR, S_DATA, S_CHK, S_ISSUE);
  - err_code enum (ERR_NONE=0, ERR_BAD_OP, ERR_BAD_CHK, ERR_TIMEOUT);
  - default SYNC_BYTE, OP_WRITE and OP_READ constants.
- Single module. No sub-module is required; the timeout counter stays inline.

Test Plan:
- Write frame A5 01 10 3C 2D with cmd_ready=1 → one cmd_valid cycle, cmd_write=1, addr=10, data=3C; no err_valid.
- Read frame A5 02 7F 00 7D with cmd_ready held low 20 cycles → cmd_valid high and stable 20 cycles, in_ready=0 throughout; releases after cmd_ready.
- Garbage 00 FF 5A, then A5 01 10 3C 2D → garbage discarded without error; the write command is issued normally.
- A5 03 → err_valid pulse with err_code=01 and err_count=1. A5 01 10 3C 2C → err_code=10, err_count=2, no cmd_valid.
- With TIMEOUT_CYCLES=100: send A5 01 then stall 100 cycles → err_code=11 in the expected cycle. A full frame sent afterwards is decoded correctly.
- Assert reset mid-frame after A5 01 10, and drop ena for 5 cycles mid-frame on a separate run → reset: all outputs 0 and no error; ena drop: frame still decodes once ena returns.
